decode_writeback: RTL
=====================

# decode_writeback

Decode/write-back stage for the SEQ Y86-64 core. It sits directly downstream of `fetch` and consumes its `icode`, `rA` and `rB` outputs. It holds the 15-entry 64-bit register file and produces the decode operands `valA`/`valB` and the register IDs `srcA`/`srcB`/`dstE`/`dstM` for execute. At the end of the instruction it commits `valE`/`valM` and latches the processor status, which is sticky.

## Interface
- `RSP_INIT`, default 64'd1024: reset value of `%rsp` (register 4).
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `icode`  in  4  instruction code from fetch.
- `rA`  in  4  register field A from fetch; 4'hF means none.
- `rB`  in  4  register field B from fetch; 4'hF means none.
- `cnd`  in  1  condition result from execute; used only for cmovXX.
- `valE`  in  64  execute result to commit.
- `valM`  in  64  memory read data to commit.
- `wb_en`  in  1  commit strobe; one pulse per instruction.
- `halt`  in  1  instruction-status flag.
- `i_error`  in  1  instruction-status flag.
- `mem_error`  in  1  instruction-status flag.
- `srcA`  out  4  decoded source register ID A.
- `srcB`  out  4  decoded source register ID B.
- `dstE`  out  4  decoded destination register ID for `valE`.
- `dstM`  out  4  decoded destination register ID for `valM`.
- `valA`  out  64  value of register `srcA`; 0 if `srcA`=F.
- `valB`  out  64  value of register `srcB`; 0 if `srcB`=F.
- `stat`  out  2  0=AOK, 1=HLT, 2=INS, 3=ADR.

## Operation
Register IDs:
- 0 rax, 1 rcx, 2 rdx, 3 rbx, 4 rsp, 5 rbp, 6 rsi, 7 rdi, 8–14 r8–r14.
- F means none: reads return 0, writes are dropped.

Decode rules, all combinational from `icode`/`rA`/`rB`/`cnd`:
- `srcA`: `rA` for icode 2, 4, 6, A; 4 for icode 9, B; else F.
- `srcB`: `rB` for icode 4, 5, 6; 4 for icode 8, 9, A, B; else F.
- `dstE`: for icode 2, `rB` if `cnd`=1, else F. `rB` for icode 3, 6. 4 for icode 8, 9, A, B. Else F.
- `dstM`: `rA` for icode 5, B; else F.

Status FSM with states RUN (`stat`=0) and STOP (`stat`=1/2/3):
- RUN → STOP on a rising edge with `wb_en`=1 and any flag set.
- Status code priority: `mem_error`→3, then `i_error`→2, then `halt`→1.
- STOP is exited only by reset.

Commit, applied at a rising edge when `wb_en`=1, state is RUN and no flag is set:
- R[`dstE`] ← `valE`.
- R[`dstM`] ← `valM`.
- If `dstE`==`dstM` (e.g. popq %rsp), `valM` wins.

Dropped writes:
- No register write occurs on the edge that enters STOP.
- No register write occurs while in STOP.
- With `wb_en`=0, state is unchanged.

Arithmetic is none; values are stored unmodified, all 64 bits.

## Timing
- Reads are combinational: `valA`/`valB` reflect register contents as of the last edge.
- There is no same-cycle bypass. The instruction being committed reads the pre-commit values.
- A write is visible on `valA`/`valB` immediately after the committing edge, i.e. to the next instruction. Latency is 1 edge.

Reset (`rst_n`=0, asynchronous, takes effect immediately, including mid-instruction):
- All registers → 0, except R[4] → `RSP_INIT`.
- `stat` → 0 (RUN).
- Any `wb_en` coincident with reset is discarded.
- Decode outputs have no state: after reset they reflect inputs, and `valA`/`valB` reflect reset contents.

## Configuration
`DECODE_DBG_EN` defined:
- Adds input `dbg_sel` [3:0] and output `dbg_data` [63:0], a combinational read of R[`dbg_sel`] (0 for F).
- Adds output `commit_cnt` [63:0], which resets to 0 and increments by 1 per accepted commit.
- Dropped commits (STOP, or the error edge) do not increment `commit_cnt`.
- The counter wraps from 2^64−1 to 0.

`DECODE_DBG_EN` undefined: these ports and this logic are absent. Functional behaviour is otherwise identical.

## Structure
- Package `y86_pkg`:
  - icode constants (HALT…POPQ).
  - Register IDs, including `RSP`=4 and `RNONE`=F.
  - `stat` encodings (AOK/HLT/INS/ADR).
  - Default `RSP_INIT`.
- Sub-module `regfile`:
  - 15×64 storage.
  - Two combinational read ports returning 0 on F.
  - Two write ports with the M-over-E priority.
  - Asynchronous active-low reset with the rsp preset.
- Decode logic, the status FSM and the debug counter stay in `decode_writeback`.

## Test plan
- Reset: pulse `rst_n` low, then sweep `dbg_sel` 0–14 → all 0 except R4=1024; `stat`=0; `commit_cnt`=0.
- irmovq: icode 3, rB=1, `valE`=18, `wb_en` pulse → `dstE`=1. Next cycle icode 6, rA=1, rB=0 → `valA`=18, `valB`=0.
- popq %rsp: icode B, rA=4, `valE`=1032, `valM`=0x55, commit → `srcA`=`srcB`=4, `dstE`=`dstM`=4; afterwards R4=0x55.
- cmovXX not-taken: icode 2, rA=0, rB=3, `cnd`=0, `valE`=7, commit → `dstE`=F, rbx unchanged. The same with `cnd`=1 → rbx=7.
- Error stop:
  - icode 3, rB=2, `valE`=9, `wb_en` with `mem_error`=1 and `halt`=1 → `stat`=3, rdx unchanged.
  - A later valid irmovq commit is ignored and `commit_cnt` is frozen.
- Async reset mid-run: write rax=5, then drop `rst_n` between clock edges → `valA` (rA=0, icode 6) reads 0 before the next edge; `stat`=0.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared constants for the SEQ Y86-64 core: instruction codes, register IDs,
// status encodings and the default stack pointer preset.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RSP   = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    localparam int NUM_REGS = 15;

    localparam logic [63:0] RSP_INIT_DEFAULT = 64'd1024;

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_INS = 2'd2,
        STAT_ADR = 2'd3
    } stat_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_STOP = 1'b1
    } wb_state_t;

endpackage

// File: rtl/regfile.sv
// 15 x 64-bit register file with two combinational read ports (ID F reads 0)
// and two write ports where the M port overrides the E port on the same ID.
// DECODE_DBG_EN adds a third combinational read port for debug.
module regfile
    import y86_pkg::*;
#(
    parameter logic [63:0] RSP_INIT = RSP_INIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef DECODE_DBG_EN
    input  logic [3:0]  dbg_sel,
    output logic [63:0] dbg_data,
`endif
    input  logic [3:0]  src_a,
    input  logic [3:0]  src_b,
    output logic [63:0] val_a,
    output logic [63:0] val_b,
    input  logic        we_e,
    input  logic [3:0]  dst_e,
    input  logic [63:0] val_e,
    input  logic        we_m,
    input  logic [3:0]  dst_m,
    input  logic [63:0] val_m
);

    logic [63:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == int'(RSP)) ? RSP_INIT : 64'd0;
            end
        end else begin
            // ID F never matches an index, so writes to "none" fall away here
            for (int i = 0; i < NUM_REGS; i++) begin
                if (we_m && (dst_m == 4'(i))) begin
                    regs[i] <= val_m;
                end else if (we_e && (dst_e == 4'(i))) begin
                    regs[i] <= val_e;
                end
            end
        end
    end

    always_comb begin
        val_a = (src_a == RNONE) ? 64'd0 : regs[src_a];
        val_b = (src_b == RNONE) ? 64'd0 : regs[src_b];
    end

`ifdef DECODE_DBG_EN
    always_comb begin
        dbg_data = (dbg_sel == RNONE) ? 64'd0 : regs[dbg_sel];
    end
`endif

endmodule

// File: rtl/decode_writeback.sv
// SEQ Y86-64 decode/write-back stage: operand decode, register file commit and
// sticky status. Define DECODE_DBG_EN for the debug read port and commit counter.
module decode_writeback
    import y86_pkg::*;
#(
    parameter logic [63:0] RSP_INIT = RSP_INIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef DECODE_DBG_EN
    input  logic [3:0]  dbg_sel,
    output logic [63:0] dbg_data,
    output logic [63:0] commit_cnt,
`endif
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        wb_en,
    input  logic        halt,
    input  logic        i_error,
    input  logic        mem_error,
    output logic [3:0]  srcA,
    output logic [3:0]  srcB,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [1:0]  stat
);

    wb_state_t state, state_next;
    stat_t     stop_code, stop_code_next;
    stat_t     fault_code;
    logic      any_flag;
    logic      commit;

    always_comb begin
        srcA = RNONE;
        case (icode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: srcA = rA;
            I_RET, I_POPQ:                      srcA = RSP;
            default:                            srcA = RNONE;
        endcase
    end

    always_comb begin
        srcB = RNONE;
        case (icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:          srcB = rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     srcB = RSP;
            default:                            srcB = RNONE;
        endcase
    end

    always_comb begin
        dstE = RNONE;
        case (icode)
            I_RRMOVQ:                           dstE = cnd ? rB : RNONE;
            I_IRMOVQ, I_OPQ:                    dstE = rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     dstE = RSP;
            default:                            dstE = RNONE;
        endcase
    end

    always_comb begin
        dstM = RNONE;
        case (icode)
            I_MRMOVQ, I_POPQ:                   dstM = rA;
            default:                            dstM = RNONE;
        endcase
    end

    always_comb begin
        any_flag = halt | i_error | mem_error;
        if (mem_error) begin
            fault_code = STAT_ADR;
        end else if (i_error) begin
            fault_code = STAT_INS;
        end else if (halt) begin
            fault_code = STAT_HLT;
        end else begin
            fault_code = STAT_AOK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            stop_code <= STAT_AOK;
        end else begin
            state     <= state_next;
            stop_code <= stop_code_next;
        end
    end

    // STOP is absorbing; only reset brings the stage back to RUN
    always_comb begin
        state_next     = state;
        stop_code_next = stop_code;
        if ((state == ST_RUN) && wb_en && any_flag) begin
            state_next     = ST_STOP;
            stop_code_next = fault_code;
        end
    end

    always_comb begin
        stat   = (state == ST_STOP) ? stop_code : STAT_AOK;
        commit = wb_en && (state == ST_RUN) && !any_flag;
    end

    regfile #(
        .RSP_INIT (RSP_INIT)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef DECODE_DBG_EN
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data),
`endif
        .src_a    (srcA),
        .src_b    (srcB),
        .val_a    (valA),
        .val_b    (valB),
        .we_e     (commit),
        .dst_e    (dstE),
        .val_e    (valE),
        .we_m     (commit),
        .dst_m    (dstM),
        .val_m    (valM)
    );

`ifdef DECODE_DBG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_cnt <= 64'd0;
        end else if (commit) begin
            commit_cnt <= commit_cnt + 64'd1;
        end
    end
`endif

endmodule
